// File: rtl/mvm_job_arbiter_pkg.sv
// mvm_arb_pkg: shared types and sizing helpers for the MVM job arbiter.
//   arb_state_e : arbiter FSM state (IDLE -> LOAD -> DRAIN -> IDLE)
//   in_beats()  : input beats per job (matrix A row-major, then matrix B)
//   out_beats() : result beats per job
//   cnt_w()     : bit width of a counter that runs 0 .. n-1
package mvm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  function automatic int in_beats(input int nrows_a, input int ncols_a, input int ncols_b);
    return nrows_a * ncols_a + ncols_a * ncols_b;
  endfunction

  function automatic int out_beats(input int nrows_a, input int ncols_b);
    return nrows_a * ncols_b;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mvm_job_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin grant.
//   req_i[1:0]  : request per requester
//   rr_next_i   : requester favoured when both request
//   gnt_o[1:0]  : one-hot grant (all zero when nobody requests)
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       rr_next_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = rr_next_i ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mvm_job_arbiter.sv
// mvm_job_arbiter: shares one matrix-vector multiply engine between two
// requester streams, one complete job at a time, round-robin across jobs.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   s0_*/s1_*                  requester input beats (valid/ready/data)
//   m0_*/m1_*                  result beats back to requesters (+overflow)
//   e_s_valid/e_data_in/e_s_ready     beats into the engine
//   e_m_valid/e_data_out/e_overflow/e_m_ready  results from the engine
//   owner       current or last grantee
//   busy        high while a job is loading or draining
//   proto_err   sticky: engine offered a result outside DRAIN
//   jobs_done   completed-job counter (wraps)
//   dbg_state_o FSM state for observation
//
// Handshake: a beat transfers on a cycle where valid and ready are both high
// at the rising clock edge; valid never depends on ready of the same port.
// LOAD and DRAIN are pure combinational passthroughs, so the arbiter adds no
// latency and holds no data.
module mvm_job_arbiter
  import mvm_arb_pkg::*;
#(
  parameter int NROWS_A = 3,
  parameter int NCOLS_A = 3,
  parameter int NCOLS_B = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s0_valid,
  input  logic [7:0]  s0_data,
  output logic        s0_ready,
  input  logic        s1_valid,
  input  logic [7:0]  s1_data,
  output logic        s1_ready,
  output logic        m0_valid,
  output logic [15:0] m0_data,
  output logic        m0_overflow,
  input  logic        m0_ready,
  output logic        m1_valid,
  output logic [15:0] m1_data,
  output logic        m1_overflow,
  input  logic        m1_ready,
  output logic        e_s_valid,
  output logic [7:0]  e_data_in,
  input  logic        e_s_ready,
  input  logic        e_m_valid,
  input  logic [15:0] e_data_out,
  input  logic        e_overflow,
  output logic        e_m_ready,
  output logic        owner,
  output logic        busy,
  output logic        proto_err,
  output logic [15:0] jobs_done,
  output logic [1:0]  dbg_state_o
);

  localparam int IN_BEATS  = in_beats(NROWS_A, NCOLS_A, NCOLS_B);
  localparam int OUT_BEATS = out_beats(NROWS_A, NCOLS_B);
  localparam int IW        = cnt_w(IN_BEATS);
  localparam int OW        = cnt_w(OUT_BEATS);
  localparam logic [IW-1:0] IN_LAST  = IW'(IN_BEATS - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(OUT_BEATS - 1);

  arb_state_e    state_q, state_d;
  logic          owner_q, owner_d;
  logic          rr_next_q, rr_next_d;
  logic [IW-1:0] in_cnt_q, in_cnt_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d;
  logic          proto_err_q, proto_err_d;
  logic [15:0]   jobs_done_q, jobs_done_d;
  logic [1:0]    gnt;

  rr_arb2 u_rr_arb2 (
    .req_i     ({s1_valid, s0_valid}),
    .rr_next_i (rr_next_q),
    .gnt_o     (gnt)
  );

  // Data paths are steered by owner unconditionally; only the valid/ready
  // strobes are gated by state.
  assign e_data_in = owner_q ? s1_data : s0_data;
  assign m0_data   = e_data_out;
  assign m1_data   = e_data_out;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_next_d   = rr_next_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    jobs_done_d = jobs_done_q;
    e_s_valid   = 1'b0;
    s0_ready    = 1'b0;
    s1_ready    = 1'b0;
    m0_valid    = 1'b0;
    m1_valid    = 1'b0;
    m0_overflow = 1'b0;
    m1_overflow = 1'b0;
    e_m_ready   = 1'b0;
    // A result offered while not draining is a protocol fault; it is left
    // unconsumed because e_m_ready stays low.
    proto_err_d = proto_err_q | (e_m_valid & (state_q != DRAIN));

    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          owner_d = gnt[1];
          state_d = LOAD;
        end
      end
      LOAD: begin
        e_s_valid = owner_q ? s1_valid : s0_valid;
        s0_ready  = ~owner_q & e_s_ready;
        s1_ready  = owner_q & e_s_ready;
        if (e_s_valid && e_s_ready) begin
          if (in_cnt_q == IN_LAST) begin
            in_cnt_d = '0;
            state_d  = DRAIN;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        m0_valid    = ~owner_q & e_m_valid;
        m1_valid    = owner_q & e_m_valid;
        m0_overflow = m0_valid & e_overflow;
        m1_overflow = m1_valid & e_overflow;
        e_m_ready   = owner_q ? m1_ready : m0_ready;
        if (e_m_valid && e_m_ready) begin
          if (out_cnt_q == OUT_LAST) begin
            out_cnt_d   = '0;
            rr_next_d   = ~owner_q;
            jobs_done_d = jobs_done_q + 16'd1;
            state_d     = IDLE;
          end else begin
            out_cnt_d = out_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      rr_next_q   <= 1'b0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      proto_err_q <= 1'b0;
      jobs_done_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_next_q   <= rr_next_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      proto_err_q <= proto_err_d;
      jobs_done_q <= jobs_done_d;
    end
  end

  assign owner       = owner_q;
  assign busy        = (state_q != IDLE);
  assign proto_err   = proto_err_q;
  assign jobs_done   = jobs_done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mvm_job_arbiter.sv
// Bench for mvm_job_arbiter: two requester drivers, a behavioural engine,
// result sinks, a job-level scoreboard (expected results from matrix math)
// and a per-cycle reference model of the grant/passthrough rules.
// Inputs are driven 1 time unit after the rising edge; everything is
// sampled on the falling edge.
module tb_mvm_job_arbiter;

  localparam int IN_BEATS  = 3 * 3 + 3 * 1;
  localparam int OUT_BEATS = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        s0_valid = 0, s1_valid = 0, m0_ready = 0, m1_ready = 0;
  logic [7:0]  s0_data = 0, s1_data = 0;
  logic        s0_ready, s1_ready, m0_valid, m1_valid, m0_overflow, m1_overflow;
  logic [15:0] m0_data, m1_data;
  logic        e_s_valid, e_s_ready = 0, e_m_valid = 0, e_overflow = 0, e_m_ready;
  logic [7:0]  e_data_in;
  logic [15:0] e_data_out = 0;
  logic        owner, busy, proto_err;
  logic [15:0] jobs_done;
  logic [1:0]  dbg_state;

  mvm_job_arbiter dut (
    .clk(clk), .reset(reset),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
    .m0_valid(m0_valid), .m0_data(m0_data), .m0_overflow(m0_overflow), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_data(m1_data), .m1_overflow(m1_overflow), .m1_ready(m1_ready),
    .e_s_valid(e_s_valid), .e_data_in(e_data_in), .e_s_ready(e_s_ready),
    .e_m_valid(e_m_valid), .e_data_out(e_data_out), .e_overflow(e_overflow), .e_m_ready(e_m_ready),
    .owner(owner), .busy(busy), .proto_err(proto_err), .jobs_done(jobs_done),
    .dbg_state_o(dbg_state)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected result beat {overflow, data} for row r of a 12-beat job.
  function automatic logic [16:0] mvm_row(input logic [7:0] b[12], input int r);
    int s;
    logic ovf;
    s = 0;
    for (int c = 0; c < 3; c++)
      s += int'($signed(b[r*3+c])) * int'($signed(b[9+c]));
    ovf = (s > 32767) || (s < -32768);
    return {ovf, s[15:0]};
  endfunction

  // ---------------- environment state ----------------
  logic [7:0]  jq0[$], jq1[$];
  logic [16:0] exp_q0[$], exp_q1[$];
  logic [7:0]  abuf0[12], abuf1[12];
  int rcnt0 = 0, rcnt1 = 0;
  bit gap_en = 0, stall_en = 0, hold0 = 0, spur = 0;
  int s0_rdy_cnt = 0, m0_hs = 0, m0_ovf_cnt = 0, tot_jobs = 0;
  int own_log[$];

  // requester + sink drivers
  always @(posedge clk) begin
    #1;
    s0_valid = (jq0.size() > 0) && (!gap_en || $urandom_range(0, 3) != 0);
    s0_data  = (jq0.size() > 0) ? jq0[0] : 8'h00;
    s1_valid = (jq1.size() > 0) && (!gap_en || $urandom_range(0, 3) != 0);
    s1_data  = (jq1.size() > 0) ? jq1[0] : 8'h00;
    m0_ready = !hold0 && (!stall_en || $urandom_range(0, 3) != 0);
    m1_ready = !stall_en || $urandom_range(0, 3) != 0;
  end

  // requester + sink samplers, scoreboard
  always @(negedge clk) begin
    logic [16:0] e;
    if (reset) begin
      rcnt0 = 0;
      rcnt1 = 0;
    end else begin
      if (s0_ready) s0_rdy_cnt++;
      if (s0_valid && s0_ready && jq0.size() > 0) begin
        abuf0[rcnt0] = jq0.pop_front();
        rcnt0++;
        if (rcnt0 == IN_BEATS) begin
          for (int r = 0; r < OUT_BEATS; r++) exp_q0.push_back(mvm_row(abuf0, r));
          rcnt0 = 0;
        end
      end
      if (s1_valid && s1_ready && jq1.size() > 0) begin
        abuf1[rcnt1] = jq1.pop_front();
        rcnt1++;
        if (rcnt1 == IN_BEATS) begin
          for (int r = 0; r < OUT_BEATS; r++) exp_q1.push_back(mvm_row(abuf1, r));
          rcnt1 = 0;
        end
      end
      if (m0_valid && m0_ready) begin
        m0_hs++;
        if (m0_overflow) m0_ovf_cnt++;
        if (exp_q0.size() == 0) check("m0_unexpected_result", 1, 0);
        else begin
          e = exp_q0.pop_front();
          check("m0_result", {m0_overflow, m0_data}, e);
        end
      end
      if (m1_valid && m1_ready) begin
        if (exp_q1.size() == 0) check("m1_unexpected_result", 1, 0);
        else begin
          e = exp_q1.pop_front();
          check("m1_result", {m1_overflow, m1_data}, e);
        end
      end
    end
  end

  // behavioural engine: collect a job, compute, stream results
  logic [7:0]  ebuf[12];
  logic [16:0] eres[3];
  int eph = 0, ecnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      eph = 0;
      ecnt = 0;
    end else if (eph == 0) begin
      if (e_s_valid && e_s_ready) begin
        ebuf[ecnt] = e_data_in;
        ecnt++;
        if (ecnt == IN_BEATS) begin
          for (int r = 0; r < OUT_BEATS; r++) eres[r] = mvm_row(ebuf, r);
          eph = 1;
          ecnt = 0;
        end
      end
    end else if (e_m_valid && e_m_ready) begin
      ecnt++;
      if (ecnt == OUT_BEATS) begin
        eph = 0;
        ecnt = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    e_s_ready = (eph == 0) && (!stall_en || $urandom_range(0, 3) != 0);
    if (eph == 1) begin
      e_m_valid = !stall_en || $urandom_range(0, 3) != 0;
      {e_overflow, e_data_out} = eres[ecnt];
    end else begin
      e_m_valid  = spur;
      e_overflow = spur;
      e_data_out = 16'($urandom_range(0, 65535));
    end
  end

  // ---------------- per-cycle reference model ----------------
  int m_st = 0, m_own = 0, m_rr = 0, m_in = 0, m_out = 0, m_jobs = 0, m_perr = 0;

  always @(negedge clk) begin
    bit x_esv, x_emr, x_m0v, x_m1v;
    x_esv = (m_st == 1) && (m_own ? s1_valid : s0_valid);
    x_emr = (m_st == 2) && (m_own ? m1_ready : m0_ready);
    x_m0v = (m_st == 2) && (m_own == 0) && e_m_valid;
    x_m1v = (m_st == 2) && (m_own == 1) && e_m_valid;
    check("e_s_valid", e_s_valid, x_esv);
    if (x_esv) check("e_data_in", e_data_in, m_own ? s1_data : s0_data);
    check("s0_ready", s0_ready, (m_st == 1) && (m_own == 0) && e_s_ready);
    check("s1_ready", s1_ready, (m_st == 1) && (m_own == 1) && e_s_ready);
    check("m0_valid", m0_valid, x_m0v);
    check("m1_valid", m1_valid, x_m1v);
    if (x_m0v) check("m0_passthru", {m0_overflow, m0_data}, {e_overflow, e_data_out});
    if (x_m1v) check("m1_passthru", {m1_overflow, m1_data}, {e_overflow, e_data_out});
    check("e_m_ready", e_m_ready, x_emr);
    check("busy", busy, m_st != 0);
    check("owner", owner, m_own);
    check("proto_err", proto_err, m_perr);
    check("jobs_done", jobs_done, m_jobs);

    if (reset) begin
      m_st = 0; m_own = 0; m_rr = 0; m_in = 0; m_out = 0; m_jobs = 0; m_perr = 0;
    end else begin
      if (e_m_valid && m_st != 2) m_perr = 1;
      case (m_st)
        0: if (s0_valid || s1_valid) begin
             m_own = (s0_valid && s1_valid) ? m_rr : (s1_valid ? 1 : 0);
             own_log.push_back(m_own);
             m_st = 1;
           end
        1: if (x_esv && e_s_ready) begin
             m_in++;
             if (m_in == IN_BEATS) begin m_in = 0; m_st = 2; end
           end
        default: if (e_m_valid && x_emr) begin
             m_out++;
             if (m_out == OUT_BEATS) begin
               m_out = 0;
               m_rr = 1 - m_own;
               m_jobs = (m_jobs + 1) % 65536;
               m_st = 0;
             end
           end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_job(input int idx, input logic [7:0] b[12]);
    for (int i = 0; i < IN_BEATS; i++)
      if (idx == 0) jq0.push_back(b[i]); else jq1.push_back(b[i]);
    tot_jobs++;
  endtask

  task automatic rand_job(output logic [7:0] b[12]);
    for (int i = 0; i < IN_BEATS; i++) b[i] = 8'($urandom_range(0, 255));
  endtask

  // Called at posedge+2; asserts reset and discards everything in flight.
  task automatic start_reset();
    reset = 1'b1;
    jq0.delete(); jq1.delete(); exp_q0.delete(); exp_q1.delete();
    tot_jobs = 0;
  endtask

  task automatic end_reset(input int n);
    repeat (n) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (jq0.size() == 0 && jq1.size() == 0 && exp_q0.size() == 0 &&
          exp_q1.size() == 0 && m_st == 0) begin
        done = 1;
        break;
      end
    end
    check(tag, done, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] jb[12];
    bit got;

    start_reset();
    end_reset(3);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_jobs_done", jobs_done, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_owner", owner, 0);
    @(posedge clk); #2;

    // single requester, A = 1..9, B = 1,1,1 -> 6, 15, 24
    s0_rdy_cnt = 0; m0_hs = 0;
    for (int i = 0; i < IN_BEATS; i++) jb[i] = (i < 9) ? 8'(i + 1) : 8'd1;
    push_job(0, jb);
    wait_idle("t1_timeout", 300);
    check("t1_s0_ready_cycles", s0_rdy_cnt, 12);
    check("t1_m0_beats", m0_hs, 3);
    check("t1_jobs_done", jobs_done, 1);

    // both requesters valid from reset; s1 A = identity, B = 2,3,4
    @(posedge clk); #2;
    start_reset();
    rand_job(jb);
    push_job(0, jb);
    for (int i = 0; i < 9; i++) jb[i] = (i % 4 == 0) ? 8'd1 : 8'd0;
    jb[9] = 8'd2; jb[10] = 8'd3; jb[11] = 8'd4;
    push_job(1, jb);
    own_log.delete();
    end_reset(2);
    wait_idle("t2_timeout", 400);
    check("t2_grants", own_log.size(), 2);
    if (own_log.size() == 2) begin
      check("t2_owner_first", own_log[0], 0);
      check("t2_owner_second", own_log[1], 1);
    end
    check("t2_jobs_done", jobs_done, 2);

    // result back-pressure on m0 while s1 is waiting
    own_log.delete(); m0_hs = 0;
    rand_job(jb); push_job(0, jb);
    rand_job(jb); push_job(1, jb);
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m0_hs >= 1) begin got = 1; break; end
    end
    check("t3_first_result_seen", got, 1);
    hold0 = 1;
    repeat (5) begin
      @(negedge clk);
      check("t3_hold_e_m_ready", e_m_ready, 0);
      check("t3_hold_owner", owner, 0);
      check("t3_hold_busy", busy, 1);
    end
    hold0 = 0;
    wait_idle("t3_timeout", 400);
    check("t3_jobs_done", jobs_done, 4);
    check("t3_grants", own_log.size(), 2);

    // spurious engine result while idle
    @(negedge clk); spur = 1;
    repeat (2) @(negedge clk);
    spur = 0;
    repeat (3) @(negedge clk);
    check("t4_proto_err", proto_err, 1);
    check("t4_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("t4_proto_err_sticky", proto_err, 1);

    // reset after 7 loaded beats, then a clean job
    @(posedge clk); #2;
    start_reset();
    end_reset(1);
    rand_job(jb); push_job(0, jb);
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (rcnt0 >= 7) begin got = 1; break; end
    end
    check("t5_seven_beats", got, 1);
    start_reset();
    end_reset(1);
    @(negedge clk);
    check("t5_busy_after_reset", busy, 0);
    check("t5_proto_err_cleared", proto_err, 0);
    check("t5_jobs_cleared", jobs_done, 0);
    @(posedge clk); #2;
    rand_job(jb); push_job(0, jb);
    wait_idle("t5_timeout", 300);
    check("t5_jobs_done", jobs_done, 1);

    // overflow on the second result only
    m0_ovf_cnt = 0;
    jb = '{8'd1, 8'd2, 8'd3, 8'd127, 8'd127, 8'd127, 8'd1, 8'd1, 8'd1, 8'd127, 8'd127, 8'd127};
    push_job(0, jb);
    wait_idle("t6_timeout", 300);
    check("t6_overflow_beats", m0_ovf_cnt, 1);
    check("t6_jobs_done", jobs_done, 2);

    // randomized traffic with stalls on every interface
    stall_en = 1; gap_en = 1;
    for (int j = 0; j < 20; j++) begin
      rand_job(jb);
      push_job($urandom_range(0, 1), jb);
      repeat ($urandom_range(0, 20)) @(posedge clk);
      #2;
    end
    wait_idle("t7_timeout", 8000);
    check("t7_jobs_total", jobs_done, tot_jobs);
    stall_en = 0; gap_en = 0;

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
